// File: rtl/iter_div_32_pkg.sv
// Shared definitions for the iterative 32-bit restoring divider.
package iter_div_32_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIXQ = 3'd3,
        FIXR = 3'd4,
        DONE = 3'd5
    } div_state_t;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/iter_div_32_if.sv
// Request/result bundle between the ALU and the divider.
interface iter_div_32_if;

    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        divByZero;

    modport master (
        output start, isSigned, dividend, divisor,
        input  quotient, remainder, busy, done, divByZero
    );

    modport slave (
        input  start, isSigned, dividend, divisor,
        output quotient, remainder, busy, done, divByZero
    );

endinterface

// File: rtl/iter_div_32_addsub.sv
// 32-bit ripple-carry adder/subtractor; carryOut=1 on subtract means no borrow.
module iter_div_32_addsub (
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        subtractNotAdd,
    output logic [31:0] result,
    output logic        carryOut
);

    logic [31:0] b_eff;
    logic        carry;

    assign b_eff = operand2 ^ {32{subtractNotAdd}};

    always_comb begin
        result = '0;
        carry  = subtractNotAdd;
        for (int i = 0; i < 32; i++) begin
            result[i] = operand1[i] ^ b_eff[i] ^ carry;
            carry     = (operand1[i] & b_eff[i]) | (carry & (operand1[i] ^ b_eff[i]));
        end
        carryOut = carry;
    end

endmodule

// File: rtl/iter_div_32.sv
// Iterative restoring divider, signed or unsigned, one trial subtraction per cycle.
//   state | meaning
//   IDLE  | wait for start; capture operands, divisor magnitude taken here
//   PREP  | divide-by-zero exit, or record signs and take dividend magnitude
//   ITER  | 32 shift/trial-subtract steps
//   FIXQ  | sign-correct quotient
//   FIXR  | sign-correct remainder
//   DONE  | one-cycle done pulse
module iter_div_32
    import iter_div_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = DIV_ITERS
) (
    input  logic          CLK,
    input  logic          RST,
    iter_div_32_if.slave  bus
);

    if (WIDTH != 32 || ITERS != WIDTH) begin : g_bad_width
        $error("iter_div_32 supports only WIDTH == ITERS == 32");
    end

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             is_signed_q, is_signed_d;
    logic             dsign_q, dsign_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_op1, add_op2, add_res;
    logic             add_sub, add_cout;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    iter_div_32_addsub u_addsub (
        .operand1       (add_op1),
        .operand2       (add_op2),
        .subtractNotAdd (add_sub),
        .result         (add_res),
        .carryOut       (add_cout)
    );

    assign shifted = {r_q[WIDTH-2:0], a_q[WIDTH-1]};
    assign accept  = r_q[WIDTH-1] | add_cout;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        cnt_d       = cnt_q;
        is_signed_d = is_signed_q;
        dsign_d     = dsign_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dbz_d       = dbz_q;
        add_op1     = '0;
        add_op2     = '0;
        add_sub     = 1'b1;
        unique case (state_q)
            IDLE: begin
                // The adder is idle here, so the divisor magnitude is formed at capture.
                add_op2 = bus.divisor;
                if (bus.start) begin
                    a_d         = bus.dividend;
                    b_d         = (bus.isSigned & bus.divisor[WIDTH-1]) ? add_res : bus.divisor;
                    dsign_d     = bus.divisor[WIDTH-1];
                    is_signed_d = bus.isSigned;
                    state_d     = PREP;
                end
            end
            PREP: begin
                if (b_q == '0) begin
                    quotient_d  = DIV_BY_ZERO_Q;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    add_op2 = a_q;
                    dbz_d   = 1'b0;
                    neg_q_d = is_signed_q & (a_q[WIDTH-1] ^ dsign_q);
                    neg_r_d = is_signed_q & a_q[WIDTH-1];
                    if (is_signed_q & a_q[WIDTH-1]) a_d = add_res;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                add_op1 = shifted;
                add_op2 = b_q;
                r_d     = accept ? add_res : shifted;
                a_d     = {a_q[WIDTH-2:0], accept};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERS - 1)) state_d = FIXQ;
            end
            FIXQ: begin
                add_op2    = a_q;
                quotient_d = neg_q_q ? add_res : a_q;
                state_d    = FIXR;
            end
            FIXR: begin
                add_op2     = r_q;
                remainder_d = neg_r_q ? add_res : r_q;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            is_signed_q <= 1'b0;
            dsign_q     <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            cnt_q       <= cnt_d;
            is_signed_q <= is_signed_d;
            dsign_q     <= dsign_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = dbz_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_iter_div_32.sv
// Directed bench for iter_div_32: hand-computed results, latency, abort and ignored start.
module tb_iter_div_32;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;
    int   n;

    iter_div_32_if bus ();

    iter_div_32 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives start ahead of edge 1 and returns just after that edge.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.start    = 1'b1;
        bus.isSigned = sgn;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
    endtask

    // Counts edges (edge 1 already taken) until done is seen, bounded.
    task automatic wait_done(output int edges);
        edges = 1;
        while (bus.done !== 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] q,
                       input logic [31:0] r, input logic dz);
        int e;
        launch(sgn, a, b);
        wait_done(e);
        check({tag, "_latency"}, e, lat);
        check({tag, "_quotient"}, bus.quotient, q);
        check({tag, "_remainder"}, bus.remainder, r);
        check({tag, "_divbyzero"}, {31'd0, bus.divByZero}, {31'd0, dz});
        tick();
        check({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        bus.start    = 1'b0;
        bus.isSigned = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        RST          = 1'b1;
        #22;
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_divbyzero", {31'd0, bus.divByZero}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // 100 / 7 unsigned with busy/done timing.
        launch(1'b0, 32'd100, 32'd7);
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (n == 2) check("u100_7_busy_e2", {31'd0, bus.busy}, 32'd1);
            if (n == 35) check("u100_7_done_e35", {31'd0, bus.done}, 32'd0);
        end
        check("u100_7_latency", n, 36);
        check("u100_7_busy_e36", {31'd0, bus.busy}, 32'd1);
        check("u100_7_quotient", bus.quotient, 32'd14);
        check("u100_7_remainder", bus.remainder, 32'd2);
        check("u100_7_divbyzero", {31'd0, bus.divByZero}, 32'd0);
        tick();
        check("u100_7_done_pulse", {31'd0, bus.done}, 32'd0);
        check("u100_7_busy_e37", {31'd0, bus.busy}, 32'd0);

        run("dbz", 1'b0, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 36, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 36, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 36, 32'h8000_0000, 32'd0, 1'b0);
        run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 36, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 36, 32'h7FFF_FFFC, 32'd1, 1'b0);

        // Second start during iteration 5 must be ignored.
        launch(1'b0, 32'd1000, 32'd3);
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            if (n == 6) begin
                bus.start    = 1'b1;
                bus.isSigned = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end
            tick();
            n++;
            bus.start = 1'b0;
        end
        check("ign_latency", n, 36);
        check("ign_quotient", bus.quotient, 32'd333);
        check("ign_remainder", bus.remainder, 32'd1);
        tick();

        // Reset during iteration 10 aborts with all outputs cleared.
        launch(1'b0, 32'd5000, 32'd7);
        repeat (11) tick();
        #2;
        RST = 1'b1;
        #1;
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_divbyzero", {31'd0, bus.divByZero}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run("post_rst", 1'b0, 32'd5000, 32'd7, 36, 32'd714, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_div_32.md
Name: iter_div_32

Overview:
- Iterative 32-bit restoring divider, signed or unsigned, with a start/done handshake.
- Sits directly downstream of the 32-bit ripple-carry add/sub unit: it drives that unit's operands and subtract control every cycle, and consumes its result and carry-out.
- Used by the ALU for DIV/REM operations.
- One trial subtraction per cycle; the same adder instance is reused for the sign-correction negations.

Parameters:
- WIDTH, 32, operand width. Fixed at 32 because the adder instance is 32-bit; any other value is a compile-time error.
- ITERS, 32, number of restoring iterations. Must equal WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- isSigned  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
- dividend  input  32  numerator; captured with start
- divisor  input  32  denominator; captured with start
- quotient  output  32  registered result
- remainder  output  32  registered result
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse; results valid from this cycle on
- divByZero  output  1  registered flag, valid with done

Behaviour:
- Reset (async, RST=1): state=IDLE; quotient, remainder, busy, done, divByZero, iteration counter and internal registers all = 0. RST asserted mid-operation aborts immediately with no partial results.
- States: IDLE -> PREP -> ITER -> FIXQ -> FIXR -> DONE -> IDLE.
- IDLE: on start=1, capture dividend, divisor and isSigned; go to PREP; busy=1 next cycle.
- PREP:
  - If divisor==0: set quotient=0xFFFFFFFF, remainder=dividend, divByZero=1, go to DONE.
  - Otherwise: record negQ = isSigned & (dividend[31]^divisor[31]) and negR = isSigned & dividend[31].
  - Replace each operand with its magnitude when isSigned and its bit31 is set. The negation uses the adder: operand1=0, operand2=value, subtractNotAdd=1.
  - Clear the partial remainder R; set Q=|dividend|; counter=0; go to ITER.
- ITER, one iteration per cycle:
  - Shift {R,Q} left by 1; let top = the bit shifted out of R.
  - Drive the adder with operand1={R[30:0],Q[31]}, operand2=|divisor|, subtractNotAdd=1.
  - Accept when top | carryOut: R<=adder result, Q[0]<=1. Otherwise R<=shifted value, Q[0]<=0.
  - counter increments each iteration; after the 32nd iteration go to FIXQ.
- FIXQ: quotient <= negQ ? (0 - Q) via the adder : Q.
- FIXR: remainder <= negR ? (0 - R) via the adder : R.
- DONE: done=1 for exactly one cycle; busy drops at the following edge; go to IDLE.
- Latency, counting the edge that samples start as edge 1:
  - Normal divide: done is high after edge 36 (1 IDLE + 1 PREP + 32 ITER + FIXQ + FIXR).
  - Divide-by-zero: done is high after edge 2.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: falls out naturally as quotient=0x80000000, remainder=0. No special case.
- start while busy: ignored; no effect on the captured operands.
- quotient, remainder and divByZero hold their values until the next accepted start. divByZero clears in PREP of a non-zero divide.
- Sign rules: the remainder takes the sign of the dividend; the quotient truncates toward zero.
- Only the add/sub unit performs arithmetic; no behavioural + or - on the datapath. The counter is the only exception.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE, PREP, ITER, FIXQ, FIXR, DONE (3-bit)
  - DIV_ITERS=32
  - the DIV_BY_ZERO_Q constant 0xFFFFFFFF
- Sub-module: the existing 32-bit ripple-carry add/sub, instantiated exactly once with operand muxing in front of it.
- No other new sub-module; the control FSM and the datapath stay in iter_div_32.

Test Plan:
- Unsigned 100 / 7:
  - quotient=14, remainder=2, divByZero=0.
  - done exactly at edge 36; busy high edges 2-36.
- Signed -7 / 2:
  - quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Signed 7 / -2 gives quotient=0xFFFFFFFD, remainder=1.
- Divide-by-zero, dividend 0x12345678 / 0:
  - quotient=0xFFFFFFFF, remainder=0x12345678, divByZero=1.
  - done at edge 2.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF / 1 gives quotient=0xFFFFFFFF, remainder=0.
- Start pulsed again at iteration 5 with different operands: ignored, and the original result is produced.
- Then RST at iteration 10 of a new divide: all outputs 0 immediately; the next start completes normally.
